l0_maxpool_reader: RTL

//  Second pass of the CNN accelerator: the reader for layer-0 memory, which the convolution pass fills.

---
 rtl/l0_maxpool_reader_if.sv | 26 ++
 rtl/l0_maxpool_reader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/l0_maxpool_reader_if.sv
// Bus between the layer-0 max-pool reader and its memories/controller.
// The master side is the reader; the slave side models the L0/L1 memories and the start control.
interface l0_maxpool_reader_if #(
    parameter int DW = 20,
    parameter int AW = 12
);
    logic          ready;
    logic          busy;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    modport master (
        input  ready, cdata_rd,
        output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output ready, cdata_rd,
        input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/l0_maxpool_reader.sv
// Layer-0 reader: 2x2 stride-2 max-pooling of the IMG_W x IMG_W L0 map into L1.
// Six cycles per output: four reads, one trailing capture, one write.
module l0_maxpool_reader #(
    parameter int         IMG_W  = 64,
    parameter int         DW     = 20,
    parameter int         AW     = 12,
    parameter logic [2:0] SEL_RD = 3'b001,
    parameter logic [2:0] SEL_WR = 3'b011
) (
    input  logic                clk,
    input  logic                reset,
    l0_maxpool_reader_if.master bus
);
    localparam int OW = IMG_W / 2;
    localparam int CW = $clog2(OW);
    localparam logic [CW-1:0] LAST_IDX = CW'(OW - 1);

    typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        row, col;
    logic [1:0]           k;
    logic                 last_out;
    logic [AW-1:0]        rd_addr, wr_addr;
    logic signed [DW-1:0] rd_word;
    logic signed [DW-1:0] max_q;
    logic [2:0]           csel_hold;
    logic [AW-1:0]        rd_addr_hold, wr_addr_hold;
    logic [DW-1:0]        wr_data_hold;

    function automatic logic signed [DW-1:0] max_sel(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        return (b > a) ? b : a;
    endfunction

    assign last_out = (row == LAST_IDX) && (col == LAST_IDX);
    assign rd_word  = $signed(bus.cdata_rd);
    // k[1] selects the lower row of the window, k[0] the right column
    assign rd_addr  = AW'(2 * int'(row) * IMG_W + 2 * int'(col)
                          + (k[1] ? IMG_W : 0) + int'(k[0]));
    assign wr_addr  = AW'(int'(row) * OW + int'(col));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ready) state_nxt = RD;
            RD:      if (k == 2'd3) state_nxt = LAST;
            LAST:    state_nxt = WR;
            WR:      state_nxt = last_out ? DONE : RD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state != IDLE);
        bus.crd      = 1'b0;
        bus.cwr      = 1'b0;
        bus.csel     = csel_hold;
        bus.caddr_rd = rd_addr_hold;
        bus.caddr_wr = wr_addr_hold;
        bus.cdata_wr = wr_data_hold;
        case (state)
            RD: begin
                bus.crd      = 1'b1;
                bus.csel     = SEL_RD;
                bus.caddr_rd = rd_addr;
            end
            WR: begin
                bus.cwr      = 1'b1;
                bus.csel     = SEL_WR;
                bus.caddr_wr = wr_addr;
                bus.cdata_wr = max_q;
            end
            default: ;
        endcase
    end

    // Held copies keep bank select, addresses and write data stable outside RD/WR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csel_hold    <= '0;
            rd_addr_hold <= '0;
            wr_addr_hold <= '0;
            wr_data_hold <= '0;
        end else begin
            csel_hold    <= bus.csel;
            rd_addr_hold <= bus.caddr_rd;
            wr_addr_hold <= bus.caddr_wr;
            wr_data_hold <= bus.cdata_wr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
            k   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                    k   <= '0;
                end
                RD: k <= k + 2'd1;
                WR: if (!last_out) begin
                    k <= '0;
                    if (col == LAST_IDX) begin
                        col <= '0;
                        row <= row + CW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data lags its address by one cycle; the word for A[0] seeds the running max
    always_ff @(posedge clk) begin
        if ((state == RD && k != 2'd0) || state == LAST)
            max_q <= (state == RD && k == 2'd1) ? rd_word : max_sel(max_q, rd_word);
    end
endmodule
